// File: rtl/trigout_ts_queue.sv
// ---------------------------------------------------------------------------
// trigout_ts_queue
//
// Captures White Rabbit timestamps for trigger events and holds them in a
// first-word fall-through queue for software to read.
//
// A qualified trigger (any enabled channel or external trigger while WR is
// enabled and valid) opens a coalescing window of G_WINDOW cycles. All enabled
// trigger bits seen during the window are ORed into a single entry. The entry
// keeps the timestamp of the first trigger. When the window closes, the entry
// is pushed into the queue. If the queue is full and no pop happens in the
// same cycle, the entry is dropped and counted.
//
// Ports
//   clk_i, rst_i      : clock and synchronous active-high reset
//   ch_trig_i[3:0]    : per-channel trigger pulses (bit n = channel n+1)
//   ext_trig_i        : external trigger pulse
//   ch_enable_i[3:0]  : per-channel trigger enables
//   ext_enable_i      : external trigger enable
//   wr_enable_i       : White Rabbit enabled
//   wr_valid_i        : White Rabbit time valid
//   tm_tai_i[39:0]    : current WR seconds
//   tm_cycles_i[27:0] : current WR cycle count
//   ts_sec_o, cycles_o, ch_mask_o, ext_mask_o : queue head (0 when empty)
//   ts_present_o      : queue not empty
//   ts_rd_i           : single-cycle pop of the head
//   overflow_o        : sticky flag, an entry was dropped
//   ovf_clr_i         : clears overflow_o and drop_cnt_o
//   drop_cnt_o[15:0]  : saturating count of dropped entries
//   level_o           : number of entries held, 0..G_DEPTH
// ---------------------------------------------------------------------------
module trigout_ts_queue #(
    parameter int G_DEPTH  = 8,
    parameter int G_WINDOW = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [3:0]                 ch_trig_i,
    input  logic                       ext_trig_i,
    input  logic [3:0]                 ch_enable_i,
    input  logic                       ext_enable_i,
    input  logic                       wr_enable_i,
    input  logic                       wr_valid_i,
    input  logic [39:0]                tm_tai_i,
    input  logic [27:0]                tm_cycles_i,
    output logic [39:0]                ts_sec_o,
    output logic [27:0]                cycles_o,
    output logic [3:0]                 ch_mask_o,
    output logic                       ext_mask_o,
    output logic                       ts_present_o,
    input  logic                       ts_rd_i,
    output logic                       overflow_o,
    input  logic                       ovf_clr_i,
    output logic [15:0]                drop_cnt_o,
    output logic [$clog2(G_DEPTH):0]   level_o
);

    localparam int AW = $clog2(G_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 40 + 28 + 4 + 1;
    localparam logic [7:0]    WIN_LOAD = 8'(G_WINDOW - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(G_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUSH    = 2'd2
    } state_t;

    // Saturating increment for the drop counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            return val;
        end
        return val + 16'd1;
    endfunction

    // ---------------------------------------------------------------------
    // Trigger qualification
    // ---------------------------------------------------------------------
    logic       wr_ok;
    logic [3:0] ch_bits;
    logic       ext_bit;
    logic       qual;

    assign wr_ok   = wr_enable_i & wr_valid_i;
    assign ch_bits = ch_trig_i & ch_enable_i & {4{wr_ok}};
    assign ext_bit = ext_trig_i & ext_enable_i & wr_ok;
    assign qual    = (|ch_bits) | ext_bit;

    // ---------------------------------------------------------------------
    // Capture state machine
    // ---------------------------------------------------------------------
    state_t      state;
    logic [7:0]  win_cnt;
    logic [39:0] pend_sec;
    logic [27:0] pend_cyc;
    logic [3:0]  pend_ch;
    logic        pend_ext;

    // Only control state is reset. The pending entry data is simply ignored
    // until the next capture overwrites it, so a reset discards it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            win_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (qual) begin
                        pend_sec <= tm_tai_i;
                        pend_cyc <= tm_cycles_i;
                        pend_ch  <= ch_bits;
                        pend_ext <= ext_bit;
                        win_cnt  <= WIN_LOAD;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    // Timestamp stays from the first trigger; only the masks
                    // accumulate. A WR valid drop only gates new bits.
                    pend_ch  <= pend_ch | ch_bits;
                    pend_ext <= pend_ext | ext_bit;
                    if (win_cnt == 8'd0) begin
                        state <= PUSH;
                    end else begin
                        win_cnt <= win_cnt - 8'd1;
                    end
                end
                PUSH: begin
                    // The entry is written to the queue this cycle; a new
                    // trigger here starts the next window immediately.
                    if (qual) begin
                        pend_sec <= tm_tai_i;
                        pend_cyc <= tm_cycles_i;
                        pend_ch  <= ch_bits;
                        pend_ext <= ext_bit;
                        win_cnt  <= WIN_LOAD;
                        state    <= COLLECT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Queue push/pop arbitration
    // ---------------------------------------------------------------------
    logic          push;
    logic          pop_ok;
    logic          push_ok;
    logic          drop;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] level;

    assign push    = (state == PUSH) && !rst_i;
    assign pop_ok  = ts_rd_i && (level != '0);
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign push_ok = push && ((level != LVL_FULL) || pop_ok);
    assign drop    = push && !push_ok;

    // ---------------------------------------------------------------------
    // Queue storage (not reset: the pointer reset empties the queue)
    // ---------------------------------------------------------------------
    logic [EW-1:0] mem [G_DEPTH];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wptr] <= {pend_sec, pend_cyc, pend_ch, pend_ext};
        end
    end

    // ---------------------------------------------------------------------
    // Queue pointers, level and overflow bookkeeping
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr       <= '0;
            rptr       <= '0;
            level      <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            // Pointers are exactly AW bits wide, so they wrap modulo G_DEPTH.
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            // A drop in the clear cycle wins, leaving a count of one.
            if (ovf_clr_i) begin
                overflow_o <= drop;
                drop_cnt_o <= drop ? 16'd1 : 16'd0;
            end else if (drop) begin
                overflow_o <= 1'b1;
                drop_cnt_o <= sat_inc16(drop_cnt_o);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Fall-through head outputs, forced to zero while empty
    // ---------------------------------------------------------------------
    logic [EW-1:0] head;

    assign head         = mem[rptr];
    assign ts_present_o = (level != '0);
    assign level_o      = level;
    assign ts_sec_o     = ts_present_o ? head[72:33] : '0;
    assign cycles_o     = ts_present_o ? head[32:5]  : '0;
    assign ch_mask_o    = ts_present_o ? head[4:1]   : '0;
    assign ext_mask_o   = ts_present_o ? head[0]     : 1'b0;

endmodule
